// File: rtl/cpu_pkg.sv
// Shared ISA definitions for the 5-bit-address RISC CPU: opcodes, sequencer
// phases and field widths.
package cpu_pkg;

    localparam int unsigned OPCODE_W = 3;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned PHASE_W  = 3;

    typedef enum logic [OPCODE_W-1:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_e;

    typedef enum logic [PHASE_W-1:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        IDLE       = 3'd3,
        OP_ADDR    = 3'd4,
        OP_FETCH   = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_e;

    // Opcodes that read an operand from memory into the accumulator path.
    function automatic logic is_aluop(opcode_e op);
        return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    endfunction

endpackage

// File: rtl/phase_counter.sv
// Wrapping 3-bit phase register for the instruction sequencer; hold freezes it.
module phase_counter
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   hold,
    output phase_e phase
);

    phase_e phase_q;
    phase_e phase_d;

    always_comb begin
        phase_d = hold ? phase_q : phase_e'(PHASE_W'(phase_q + 3'd1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= INST_ADDR;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/sequence_controller.sv
// Eight-phase fetch/execute sequencer and control-line decode.
// Build option SEQ_CTRL_HALT_LATCH_EN makes HLT freeze the sequencer until reset.
module sequence_controller
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    output logic                sel,
    output logic                rd,
    output logic                wr,
    output logic                ld_ir,
    output logic                ld_ac,
    output logic                ld_pc,
    output logic                inc_pc,
    output logic                halt,
    output logic                data_e
);

    phase_e  phase;
    opcode_e op;
    logic    hold;
    logic    halted;
    logic    alu;
    logic    is_sto;
    logic    is_jmp;

    assign op     = opcode_e'(opcode);
    assign alu    = is_aluop(op);
    assign is_sto = (op == STO);
    assign is_jmp = (op == JMP);

`ifdef SEQ_CTRL_HALT_LATCH_EN
    logic halt_q;
    logic halt_d;

    // Hold in the decode cycle too, so the phase never leaves OP_ADDR.
    always_comb begin
        halt_d = halt_q || ((phase == OP_ADDR) && (op == HLT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign hold   = halt_d;
    assign halted = halt_q;
`else
    assign hold   = 1'b0;
    assign halted = 1'b0;
`endif

    phase_counter u_phase_counter (
        .clk   (clk),
        .rst   (rst),
        .hold  (hold),
        .phase (phase)
    );

    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        wr     = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        data_e = 1'b0;
        case (phase)
            INST_ADDR: begin
                sel = 1'b1;
            end
            INST_FETCH: begin
                sel = 1'b1;
                rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
                sel   = 1'b1;
                rd    = 1'b1;
                ld_ir = 1'b1;
            end
            OP_ADDR: begin
                inc_pc = !halted;
                halt   = halted || (op == HLT);
            end
            OP_FETCH: begin
                rd = alu;
            end
            ALU_OP: begin
                rd     = alu;
                inc_pc = (op == SKZ) && zero;
                ld_pc  = is_jmp;
                data_e = is_sto;
            end
            STORE: begin
                rd     = alu;
                ld_ac  = alu;
                ld_pc  = is_jmp;
                inc_pc = is_jmp;
                wr     = is_sto;
                data_e = is_sto;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/sequence_controller.md
# sequence_controller

Eight-phase instruction sequencer for the 5-bit-address RISC CPU. Cycles through fetch/execute phases and decodes the 3-bit opcode to drive every datapath control line, including `sel` for the address mux, which picks program-counter versus instruction-register operand address. Sits between the instruction register/accumulator and the datapath (address mux, PC, IR, AC, memory, bus driver).

## Interface
- No parameters; the opcode and phase widths (3 bits each) are fixed by the ISA.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `opcode`  in  3  opcode field from the instruction register.
- `zero`  in  1  accumulator-is-zero flag.
- `sel`  out  1  address mux select; 1 = PC address (instruction fetch), 0 = IR operand address.
- `rd`  out  1  memory read.
- `wr`  out  1  memory write.
- `ld_ir`  out  1  load instruction register.
- `ld_ac`  out  1  load accumulator.
- `ld_pc`  out  1  load PC from IR address field.
- `inc_pc`  out  1  increment PC.
- `halt`  out  1  halt indication.
- `data_e`  out  1  enable accumulator onto data bus.

## Operation
- **Opcodes:** HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- **ALUOP:** asserted when the opcode is one of ADD, AND, XOR, LDA.
- **Phase register:** 3 bits. Sequence: INST_ADDR(0) → INST_FETCH(1) → INST_LOAD(2) → IDLE(3) → OP_ADDR(4) → OP_FETCH(5) → ALU_OP(6) → STORE(7). After STORE the register wraps to INST_ADDR.
- **Output decode:** outputs are a pure decode of the current phase and `opcode`. Any signal not listed for a phase is 0.
  - INST_ADDR: `sel`.
  - INST_FETCH: `sel`, `rd`.
  - INST_LOAD: `sel`, `rd`, `ld_ir`.
  - IDLE: `sel`, `rd`, `ld_ir`.
  - OP_ADDR: `inc_pc`=1; `halt`=(opcode==HLT).
  - OP_FETCH: `rd`=ALUOP.
  - ALU_OP: `rd`=ALUOP; `inc_pc`=(SKZ && `zero`); `ld_pc`=JMP; `data_e`=STO.
  - STORE: `rd`=ALUOP; `ld_ac`=ALUOP; `ld_pc`=JMP; `inc_pc`=JMP; `wr`=STO; `data_e`=STO.
- **Opcode sampling:** `opcode` is only meaningful from OP_ADDR through STORE. Fetch-phase outputs ignore it.
- **Reset:** asynchronous; phase forced to INST_ADDR. While `rst` is high: `sel`=1, all other outputs 0.
- **Reset mid-instruction:** the instruction is abandoned. Deassertion restarts cleanly at INST_ADDR with no partial `wr`.

## Timing
- Exactly one phase per `clk` cycle; one instruction every 8 cycles.
- Outputs change combinationally after the phase register updates; there is no added latency.
- The first rising edge after `rst` deasserts moves the phase INST_ADDR → INST_FETCH.
- `opcode` and `zero` must be stable during the phase that decodes them. `zero` is sampled in ALU_OP only.
- `ld_ir` is asserted for two consecutive cycles (INST_LOAD, IDLE). The IR must tolerate a double load.
- **Simultaneous events:**
  - JMP asserts `ld_pc` and `inc_pc` together in STORE. The PC must give `ld_pc` priority.
  - A SKZ with `zero`=0 is a no-op apart from the OP_ADDR increment.

## Configuration
- **Macro:** `SEQ_CTRL_HALT_LATCH_EN`.
- **Undefined:** `halt` is a single-cycle pulse in OP_ADDR for HLT, and sequencing continues. The external clock gate is responsible for stopping the CPU.
- **Defined:**
  - On HLT in OP_ADDR, a sticky halt flag sets at the next edge.
  - The phase then freezes at OP_ADDR with `halt`=1 and `inc_pc`=0 until `rst`.
  - The cycle in which HLT is first decoded still asserts `inc_pc`=1, matching the undefined build.
  - `rst` clears the flag asynchronously.

## Structure
- **Shared package `cpu_pkg`:** opcode constants (HLT…JMP), phase encodings (INST_ADDR…STORE), OPCODE_W=3, ADDR_W=5.
- **Sub-module `phase_counter`:**
  - 3-bit wrapping counter with asynchronous active-high `rst` and a `hold` input.
  - `hold` is tied 0 unless `SEQ_CTRL_HALT_LATCH_EN` is defined.
  - The decode logic stays in `sequence_controller`.

## Test plan
- **Reset:** assert `rst` mid-phase 5 → phase is 0 immediately, `sel`=1, all others 0. Release → phases 0..7 appear on successive edges, then wrap to 0.
- **LDA (opcode=5):**
  - phases 0–3 show `sel`; `rd` is 1 in phases 1–3; `ld_ir` is 1 in phases 2–3.
  - phase 4: `inc_pc`=1.
  - phases 5–7: `rd`=1.
  - phase 7: `ld_ac`=1; `wr`=0.
- **STO (opcode=6):** phase 6 gives `data_e`=1, `wr`=0. Phase 7 gives `data_e`=1, `wr`=1. `rd`=0 throughout phases 5–7.
- **SKZ (opcode=1):** `zero`=1 → `inc_pc`=1 in phase 6. `zero`=0 → `inc_pc`=0 in phase 6. Both cases give `inc_pc`=1 in phase 4.
- **JMP (opcode=7):** phase 6 gives `ld_pc`=1. Phase 7 gives `ld_pc`=1, `inc_pc`=1. `rd`=0 and `ld_ac`=0 throughout.
- **HLT (opcode=0):**
  - Macro undefined: `halt`=1 in phase 4 only, and the sequence continues to phase 5.
  - Macro defined: phase stays 4 with `halt`=1 for 20 cycles. `rst` then returns the phase to 0 with `halt`=0.
